mips_pipe_ctrl: RTL and testbench

Parametrised pipeline controller for the five-stage MIPS core. It replaces the ad-hoc `hit` fan-out and the unconditional `PCSrc` path with one block that owns the pipeline control. That control covers stall, flush and bubble insertion, EX-stage operand forwarding, and per-stage valid tracking. It keeps its own shadow copy of destination/control bits for EX, MEM and WB, so the datapath registers need only enable/flush inputs.

---
 rtl/mips_pipe_pkg.sv | 26 ++
 rtl/mips_pipe_ctrl_if.sv | 46 ++++
 rtl/mips_fwd_sel.sv | 22 ++
 rtl/mips_pipe_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_mips_pipe_ctrl.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pipe_pkg.sv
// Shared constants and types for the five-stage MIPS pipeline controller.
package mips_pipe_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic [1:0] {
    MODE_NORMAL,
    MODE_FREEZE,
    MODE_FLUSH,
    MODE_STALL
  } pipe_mode_e;

  // Width-independent part of a shadow entry; the top wraps it with RA_W-wide address fields.
  typedef struct packed {
    logic valid;
    logic uses_rs;
    logic uses_rt;
    logic reg_write;
    logic mem_read;
  } stage_ctrl_t;

  localparam stage_ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/mips_pipe_ctrl_if.sv
// Datapath <-> pipeline-controller bundle: ID-stage inputs, register enables/flushes, forwarding, counters.
interface mips_pipe_ctrl_if #(
  parameter int RA_W  = 5,
  parameter int CNT_W = 32
);
  logic            hit;
  logic            id_valid;
  logic [RA_W-1:0] id_rs;
  logic [RA_W-1:0] id_rt;
  logic            id_uses_rs;
  logic            id_uses_rt;
  logic [RA_W-1:0] id_dest;
  logic            id_reg_write;
  logic            id_mem_read;
  logic            mem_branch_taken;

  logic             pc_en;
  logic             ifid_en;
  logic             idex_en;
  logic             exmem_en;
  logic             memwb_en;
  logic             ifid_flush;
  logic             idex_flush;
  logic             exmem_flush;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic [CNT_W-1:0] retire_cnt;

  modport master (
    output hit, id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_dest,
           id_reg_write, id_mem_read, mem_branch_taken,
    input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, exmem_flush, fwd_a, fwd_b,
           stall_cnt, flush_cnt, retire_cnt
  );

  modport slave (
    input  hit, id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_dest,
           id_reg_write, id_mem_read, mem_branch_taken,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, exmem_flush, fwd_a, fwd_b,
           stall_cnt, flush_cnt, retire_cnt
  );
endinterface

// File: rtl/mips_fwd_sel.sv
// One EX operand's forward select: MEM beats WB, register 0 never forwards.
module mips_fwd_sel
  import mips_pipe_pkg::*;
#(
  parameter int RA_W = 5
) (
  input  logic [RA_W-1:0] src_i,
  input  logic            mem_valid_i,
  input  logic            mem_reg_write_i,
  input  logic [RA_W-1:0] mem_dest_i,
  input  logic            wb_valid_i,
  input  logic            wb_reg_write_i,
  input  logic [RA_W-1:0] wb_dest_i,
  output logic [1:0]      sel_o
);
  logic mem_hit;
  logic wb_hit;

  assign mem_hit = mem_valid_i && mem_reg_write_i && (mem_dest_i != '0) && (mem_dest_i == src_i);
  assign wb_hit  = wb_valid_i  && wb_reg_write_i  && (wb_dest_i  != '0) && (wb_dest_i  == src_i);
  assign sel_o   = mem_hit ? FWD_MEM : (wb_hit ? FWD_WB : FWD_RF);
endmodule

// File: rtl/mips_pipe_ctrl.sv
// Pipeline controller: freeze/flush/stall, EX forwarding, shadow EX/MEM/WB entries.
// Define MIPS_PIPE_PERF_EN to build the stall/flush/retire counters; otherwise they read 0.
module mips_pipe_ctrl
  import mips_pipe_pkg::*;
#(
  parameter int RA_W  = 5,
  parameter int CNT_W = 32
) (
  input logic            clk,
  input logic            rst,
  mips_pipe_ctrl_if.slave bus
);
  typedef struct packed {
    stage_ctrl_t     ctrl;
    logic [RA_W-1:0] rs;
    logic [RA_W-1:0] rt;
    logic [RA_W-1:0] dest;
  } shadow_t;

  shadow_t    ex_q, mem_q, wb_q;
  shadow_t    ex_d, mem_d, wb_d;
  shadow_t    id_entry;
  pipe_mode_e mode;
  logic       load_use;
  logic       pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic       ifid_flush, idex_flush, exmem_flush;

  always_comb begin
    id_entry.ctrl.valid     = bus.id_valid;
    id_entry.ctrl.uses_rs   = bus.id_uses_rs;
    id_entry.ctrl.uses_rt   = bus.id_uses_rt;
    id_entry.ctrl.reg_write = bus.id_reg_write;
    id_entry.ctrl.mem_read  = bus.id_mem_read;
    id_entry.rs             = bus.id_rs;
    id_entry.rt             = bus.id_rt;
    id_entry.dest           = bus.id_dest;
  end

  assign load_use = ex_q.ctrl.valid && ex_q.ctrl.mem_read && (ex_q.dest != '0) && bus.id_valid &&
                    ((bus.id_uses_rs && (bus.id_rs == ex_q.dest)) ||
                     (bus.id_uses_rt && (bus.id_rt == ex_q.dest)));

  always_comb begin
    mode = MODE_NORMAL;
    if (!bus.hit)                                        mode = MODE_FREEZE;
    else if (bus.mem_branch_taken && mem_q.ctrl.valid)   mode = MODE_FLUSH;
    else if (load_use)                                   mode = MODE_STALL;
  end

  // NOTE: every output gets its default first, so no path through the case leaves a latch.
  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    idex_en     = 1'b1;
    exmem_en    = 1'b1;
    memwb_en    = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    case (mode)
      MODE_FREEZE: begin
        pc_en    = 1'b0;
        ifid_en  = 1'b0;
        idex_en  = 1'b0;
        exmem_en = 1'b0;
        memwb_en = 1'b0;
      end
      MODE_FLUSH: begin
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        exmem_flush = 1'b1;
      end
      MODE_STALL: begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_flush = 1'b1;
      end
      default: ;
    endcase
  end

  // The taken branch itself still moves into WB, but as a non-retiring entry.
  always_comb begin
    ex_d  = id_entry;
    mem_d = ex_q;
    wb_d  = mem_q;
    case (mode)
      MODE_FREEZE: begin
        ex_d  = ex_q;
        mem_d = mem_q;
        wb_d  = wb_q;
      end
      MODE_FLUSH: begin
        ex_d.ctrl      = CTRL_BUBBLE;
        mem_d.ctrl     = CTRL_BUBBLE;
        wb_d.ctrl.valid = 1'b0;
      end
      MODE_STALL: ex_d.ctrl = CTRL_BUBBLE;
      default: ;
    endcase
  end

  // NOTE: payload fields are cleared along with the valid bits so no X ever reaches the compares.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      // NOTE: non-blocking so every stage samples its predecessor's pre-edge value.
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
    end
  end

  mips_fwd_sel #(.RA_W(RA_W)) u_fwd_a (
    .src_i          (ex_q.rs),
    .mem_valid_i    (mem_q.ctrl.valid),
    .mem_reg_write_i(mem_q.ctrl.reg_write),
    .mem_dest_i     (mem_q.dest),
    .wb_valid_i     (wb_q.ctrl.valid),
    .wb_reg_write_i (wb_q.ctrl.reg_write),
    .wb_dest_i      (wb_q.dest),
    .sel_o          (bus.fwd_a)
  );

  mips_fwd_sel #(.RA_W(RA_W)) u_fwd_b (
    .src_i          (ex_q.rt),
    .mem_valid_i    (mem_q.ctrl.valid),
    .mem_reg_write_i(mem_q.ctrl.reg_write),
    .mem_dest_i     (mem_q.dest),
    .wb_valid_i     (wb_q.ctrl.valid),
    .wb_reg_write_i (wb_q.ctrl.reg_write),
    .wb_dest_i      (wb_q.dest),
    .sel_o          (bus.fwd_b)
  );

  assign bus.pc_en       = pc_en;
  assign bus.ifid_en     = ifid_en;
  assign bus.idex_en     = idex_en;
  assign bus.exmem_en    = exmem_en;
  assign bus.memwb_en    = memwb_en;
  assign bus.ifid_flush  = ifid_flush;
  assign bus.idex_flush  = idex_flush;
  assign bus.exmem_flush = exmem_flush;

`ifdef MIPS_PIPE_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d;

  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    retire_cnt_d = retire_cnt_q;
    if (mode == MODE_FREEZE || mode == MODE_STALL) stall_cnt_d  = stall_cnt_q + CNT_W'(1);
    if (mode == MODE_FLUSH)                        flush_cnt_d  = flush_cnt_q + CNT_W'(1);
    if (wb_q.ctrl.valid && memwb_en)               retire_cnt_d = retire_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
      retire_cnt_q <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

  assign bus.stall_cnt  = stall_cnt_q;
  assign bus.flush_cnt  = flush_cnt_q;
  assign bus.retire_cnt = retire_cnt_q;
`else
  assign bus.stall_cnt  = {CNT_W{1'b0}};
  assign bus.flush_cnt  = {CNT_W{1'b0}};
  assign bus.retire_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_mips_pipe_ctrl.sv
// Self-checking bench: a small program flows through an instruction-level pipeline model; outputs checked every cycle.
module tb_mips_pipe_ctrl;

`ifdef MIPS_PIPE_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  localparam int NPROG = 28;

  typedef struct {
    int rs;
    int rt;
    bit urs;
    bit urt;
    int dest;
    bit rw;
    bit mr;
    bit br;
    int target;
  } instr_t;

  logic clk;
  logic rst;
  mips_pipe_ctrl_if #(.RA_W(5), .CNT_W(32)) bus ();

  mips_pipe_ctrl #(.RA_W(5), .CNT_W(32)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  instr_t prog [0:NPROG-1];

  // Model state: program indices held by each stage (-1 = bubble) plus fetch pointer.
  int m_ifid, m_ex, m_mem, m_wb, m_pc;
  int m_stall, m_flush, m_retire;
  int frz_left;
  bit post_rst, did_rst;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic instr_t mk(int rs, int rt, bit urs, bit urt, int dest, bit rw, bit mr,
                                bit br = 1'b0, int target = 0);
    instr_t i;
    i.rs = rs; i.rt = rt; i.urs = urs; i.urt = urt; i.dest = dest;
    i.rw = rw; i.mr = mr; i.br = br; i.target = target;
    return i;
  endfunction

  function automatic int fwd_of(int src);
    if (m_mem >= 0 && prog[m_mem].rw && prog[m_mem].dest != 0 && prog[m_mem].dest == src) return 2;
    if (m_wb  >= 0 && prog[m_wb].rw  && prog[m_wb].dest  != 0 && prog[m_wb].dest  == src) return 1;
    return 0;
  endfunction

  bit e_frz, e_fl, e_lu, hit_v, rst_v, spur;

  task automatic compare_model();
    check("pc_en",       32'(bus.pc_en),       32'(!e_frz && !e_lu));
    check("ifid_en",     32'(bus.ifid_en),     32'(!e_frz && !e_lu));
    check("idex_en",     32'(bus.idex_en),     32'(!e_frz));
    check("exmem_en",    32'(bus.exmem_en),    32'(!e_frz));
    check("memwb_en",    32'(bus.memwb_en),    32'(!e_frz));
    check("ifid_flush",  32'(bus.ifid_flush),  32'(e_fl));
    check("idex_flush",  32'(bus.idex_flush),  32'(e_fl || e_lu));
    check("exmem_flush", 32'(bus.exmem_flush), 32'(e_fl));
    if (m_ex >= 0) begin
      check("fwd_a", 32'(bus.fwd_a), 32'(fwd_of(prog[m_ex].rs)));
      check("fwd_b", 32'(bus.fwd_b), 32'(fwd_of(prog[m_ex].rt)));
    end
    check("stall_cnt",  bus.stall_cnt,  PERF ? 32'(m_stall)  : 32'd0);
    check("flush_cnt",  bus.flush_cnt,  PERF ? 32'(m_flush)  : 32'd0);
    check("retire_cnt", bus.retire_cnt, PERF ? 32'(m_retire) : 32'd0);
  endtask

  // Hand-computed expectations tied to specific points of the program.
  task automatic literal_pins();
    if (m_ex == 1) check("lit_fwd_a_mem_b2b", 32'(bus.fwd_a), 32'h2);
    if (m_ex == 2) begin
      check("lit_fwd_a_wb_b2b", 32'(bus.fwd_a), 32'h1);
      check("lit_fwd_b_mem",    32'(bus.fwd_b), 32'h2);
    end
    if (m_ifid == 4 && m_ex == 3) begin
      check("lit_lu_pc_en",      32'(bus.pc_en),      32'h0);
      check("lit_lu_ifid_en",    32'(bus.ifid_en),    32'h0);
      check("lit_lu_idex_flush", 32'(bus.idex_flush), 32'h1);
    end
    if (m_ex == 4) begin
      check("lit_lu_fwd_a_wb",  32'(bus.fwd_a),  32'h1);
      check("lit_lu_stall_cnt", bus.stall_cnt, PERF ? 32'd1 : 32'd0);
    end
    if (m_ex == 6) begin
      check("lit_r0_fwd_a", 32'(bus.fwd_a), 32'h0);
      check("lit_r0_fwd_b", 32'(bus.fwd_b), 32'h0);
    end
    if (m_ifid == 8 && m_ex == 7) check("lit_lw_r0_no_stall", 32'(bus.pc_en), 32'h1);
    if (m_mem == 9 && hit_v) begin
      check("lit_br_ifid_flush",  32'(bus.ifid_flush),  32'h1);
      check("lit_br_idex_flush",  32'(bus.idex_flush),  32'h1);
      check("lit_br_exmem_flush", 32'(bus.exmem_flush), 32'h1);
      check("lit_br_over_lu_pc",  32'(bus.pc_en),       32'h1);
    end
    if (m_ex == 14) begin
      check("lit_flush_cnt_1",     bus.flush_cnt,  PERF ? 32'd1 : 32'd0);
      check("lit_retire_cnt_9",    bus.retire_cnt, PERF ? 32'd9 : 32'd0);
      check("lit_stall_cnt_1",     bus.stall_cnt,  PERF ? 32'd1 : 32'd0);
      check("lit_spurious_taken",  32'(bus.exmem_flush), 32'h0);
    end
    if (m_ex == 16) begin
      check("lit_mem_over_wb", 32'(bus.fwd_a), 32'h2);
      check("lit_no_fwd_b",    32'(bus.fwd_b), 32'h0);
    end
    if (m_ex == 18) check("lit_skip_nowrite_mem", 32'(bus.fwd_a), 32'h1);
    if (m_mem == 19 && !hit_v) begin
      check("lit_frz_pc_en",       32'(bus.pc_en),    32'h0);
      check("lit_frz_memwb_en",    32'(bus.memwb_en), 32'h0);
      check("lit_frz_ignore_br",   32'(bus.ifid_flush), 32'h0);
    end
    if (m_mem == 19 && hit_v) begin
      check("lit_frz_stall_cnt_5", bus.stall_cnt, PERF ? 32'd5 : 32'd0);
      check("lit_frz_then_flush",  32'(bus.exmem_flush), 32'h1);
    end
    if (post_rst) begin
      check("lit_rst_pc_en",      32'(bus.pc_en),      32'h1);
      check("lit_rst_idex_flush", 32'(bus.idex_flush), 32'h0);
      check("lit_rst_stall_cnt",  bus.stall_cnt,  32'd0);
      check("lit_rst_flush_cnt",  bus.flush_cnt,  32'd0);
      check("lit_rst_retire_cnt", bus.retire_cnt, 32'd0);
    end
  endtask

  task automatic drive_id();
    bus.hit              = hit_v;
    bus.mem_branch_taken = (m_mem >= 0) ? prog[m_mem].br : spur;
    if (m_ifid >= 0) begin
      bus.id_valid     = 1'b1;
      bus.id_rs        = 5'(prog[m_ifid].rs);
      bus.id_rt        = 5'(prog[m_ifid].rt);
      bus.id_uses_rs   = prog[m_ifid].urs;
      bus.id_uses_rt   = prog[m_ifid].urt;
      bus.id_dest      = 5'(prog[m_ifid].dest);
      bus.id_reg_write = prog[m_ifid].rw;
      bus.id_mem_read  = prog[m_ifid].mr;
    end else begin
      bus.id_valid     = 1'b0;
      bus.id_rs        = '0;
      bus.id_rt        = '0;
      bus.id_uses_rs   = 1'b0;
      bus.id_uses_rt   = 1'b0;
      bus.id_dest      = '0;
      bus.id_reg_write = 1'b0;
      bus.id_mem_read  = 1'b0;
    end
  endtask

  task automatic model_reset();
    m_ifid = -1; m_ex = -1; m_mem = -1; m_wb = -1;
    m_stall = 0; m_flush = 0; m_retire = 0;
  endtask

  task automatic model_advance();
    post_rst = 1'b0;
    if (rst_v) begin
      model_reset();
      post_rst = 1'b1;
    end else if (e_frz) begin
      m_stall++;
      if (frz_left > 0) frz_left--;
    end else if (e_fl) begin
      m_flush++;
      if (m_wb >= 0) m_retire++;
      m_pc = prog[m_mem].target;
      m_wb = -1; m_mem = -1; m_ex = -1; m_ifid = -1;
    end else if (e_lu) begin
      m_stall++;
      if (m_wb >= 0) m_retire++;
      m_wb = m_mem; m_mem = m_ex; m_ex = -1;
    end else begin
      if (m_wb >= 0) m_retire++;
      m_wb = m_mem; m_mem = m_ex; m_ex = m_ifid;
      m_ifid = (m_pc < NPROG) ? m_pc : -1;
      m_pc++;
    end
  endtask

  initial begin
    prog[0]  = mk(1, 2, 1, 1, 3, 1, 0);          // add $3
    prog[1]  = mk(3, 1, 1, 1, 4, 1, 0);          // sub $4 <- $3
    prog[2]  = mk(3, 4, 1, 1, 6, 1, 0);          // or $6 <- $3,$4
    prog[3]  = mk(2, 0, 1, 0, 5, 1, 1);          // lw $5
    prog[4]  = mk(5, 1, 1, 1, 7, 1, 0);          // add <- $5
    prog[5]  = mk(1, 2, 1, 1, 0, 1, 0);          // add $0
    prog[6]  = mk(0, 0, 1, 1, 8, 1, 0);          // reads $0
    prog[7]  = mk(1, 0, 1, 0, 0, 1, 1);          // lw $0
    prog[8]  = mk(0, 0, 1, 1, 13, 1, 0);         // reads $0 after lw $0
    prog[9]  = mk(1, 2, 1, 1, 0, 0, 0, 1, 14);   // beq taken -> 14
    prog[10] = mk(2, 0, 1, 0, 9, 1, 1);          // lw $9 (wrong path)
    prog[11] = mk(9, 9, 1, 1, 19, 1, 0);         // load-use with lw $9
    prog[12] = mk(1, 1, 1, 1, 19, 1, 0);
    prog[13] = mk(1, 1, 1, 1, 19, 1, 0);
    prog[14] = mk(1, 2, 1, 1, 10, 1, 0);         // add $10
    prog[15] = mk(10, 1, 1, 1, 10, 1, 0);        // add $10 <- $10
    prog[16] = mk(10, 11, 1, 1, 14, 1, 0);       // $10 in MEM and WB
    prog[17] = mk(1, 14, 1, 1, 14, 0, 0);        // sw (no reg write)
    prog[18] = mk(14, 1, 1, 1, 15, 1, 0);        // reads $14 past the sw
    prog[19] = mk(1, 2, 1, 1, 0, 0, 0, 1, 24);   // beq taken -> 24 (frozen in MEM)
    prog[20] = mk(1, 1, 1, 1, 20, 1, 0);
    prog[21] = mk(1, 1, 1, 1, 21, 1, 0);
    prog[22] = mk(1, 1, 1, 1, 22, 1, 0);
    prog[23] = mk(1, 1, 1, 1, 23, 1, 0);
    prog[24] = mk(1, 0, 1, 0, 12, 1, 1);         // lw $12
    prog[25] = mk(12, 1, 1, 1, 16, 1, 0);        // load-use, reset lands here
    prog[26] = mk(16, 1, 1, 1, 17, 1, 0);
    prog[27] = mk(17, 0, 1, 1, 18, 1, 0);

    model_reset();
    m_pc = 0; frz_left = 4; post_rst = 1'b0; did_rst = 1'b0; spur = 1'b0;
    hit_v = 1'b1;
    rst = 1'b1;
    drive_id();
    repeat (2) @(posedge clk);

    for (int c = 0; c < 70; c++) begin
      @(negedge clk);
      rst_v = (m_ifid == 25 && m_ex == 24 && !did_rst);
      if (rst_v) did_rst = 1'b1;
      hit_v = !(m_mem == 19 && frz_left > 0);
      spur  = (m_ex == 14);
      rst   = rst_v;
      drive_id();
      e_frz = !hit_v;
      e_fl  = hit_v && m_mem >= 0 && prog[m_mem].br;
      e_lu  = hit_v && !e_fl && m_ex >= 0 && m_ifid >= 0 && prog[m_ex].mr && prog[m_ex].dest != 0 &&
              ((prog[m_ifid].urs && prog[m_ifid].rs == prog[m_ex].dest) ||
               (prog[m_ifid].urt && prog[m_ifid].rt == prog[m_ex].dest));
      #1;
      if (!rst_v) begin
        compare_model();
        literal_pins();
      end
      @(posedge clk);
      model_advance();
    end
    check("reset_pulse_reached", 32'(did_rst), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
